// File: rtl/measure_ctrl_pkg.sv
// Shared definitions for the measurement controller and the datapath top
// that instantiates it: default widths, clear length and the FSM state type.
package measure_ctrl_pkg;

    localparam int CNT_WIDTH_DEF  = 32;
    localparam int CLR_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_SETTLE,
        S_ACCUM,
        S_DONE
    } state_e;

endpackage

// File: rtl/measure_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single-bit level coming from another clock domain.
// Ports: clk_i / rst_n_i   destination clock, async active-low reset
//        d_i               asynchronous input
//        q_o               synchronized output (two clk_i cycles of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/measure_ctrl.sv
// Measurement sequencer: for each of num_meas_i measurements it resets the
// datapath, waits for its completion flag, captures the interval count and
// accumulates sum/min/max. A run ends on the last measurement or on timeout.
// Ports: clk_i, rst_n_i             clock, async active-low reset
//        start_i, num_meas_i        run request and measurement count
//        intval_cnt_i, cnt_valid_i  datapath result and its (async) valid flag
//        meas_rst_o                 active-high datapath reset
//        busy_o, err_timeout_o      run in progress / last run aborted
//        res_*_o, res_valid_o, res_ready_i   result bundle with handshake
//
// state    | meaning
// S_IDLE   | waiting for start
// S_CLEAR  | datapath held in reset for CLR_CYCLES cycles
// S_WAIT   | waiting for completion event, timeout counter running
// S_SETTLE | two cycles before sampling the interval count
// S_ACCUM  | fold captured count into sum/min/max
// S_DONE   | results presented until res_ready_i
module measure_ctrl
    import measure_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int NUM_W      = 8,
    parameter int TIMEOUT    = 1048576,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [NUM_W-1:0]           num_meas_i,
    input  logic [CNT_WIDTH-1:0]       intval_cnt_i,
    input  logic                       cnt_valid_i,
    output logic                       meas_rst_o,
    output logic                       busy_o,
    output logic                       err_timeout_o,
    output logic [CNT_WIDTH+NUM_W-1:0] res_sum_o,
    output logic [CNT_WIDTH-1:0]       res_min_o,
    output logic [CNT_WIDTH-1:0]       res_max_o,
    output logic [NUM_W-1:0]           res_n_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i
);

    localparam int SW = CNT_WIDTH + NUM_W;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PW = $clog2(CLR_CYCLES + 2);

    state_e               state_q, state_d;
    logic                 meas_rst_q;
    logic [NUM_W-1:0]     num_q, num_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [PW-1:0]        ph_cnt_q, ph_cnt_d;
    logic [CNT_WIDTH-1:0] cap_q, cap_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [NUM_W-1:0]     n_q, n_d;
    logic [CNT_WIDTH-1:0] min_q, min_d;
    logic [CNT_WIDTH-1:0] max_q, max_d;
    logic                 err_q, err_d;
    logic                 vld_sync;
    logic                 vld_prev_q;
    logic                 evt;

    sync_2ff u_sync_valid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (cnt_valid_i),
        .q_o     (vld_sync)
    );

    assign evt = vld_sync & ~vld_prev_q;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        to_cnt_d = to_cnt_q;
        ph_cnt_d = ph_cnt_q;
        cap_d    = cap_q;
        sum_d    = sum_q;
        n_d      = n_q;
        min_d    = min_q;
        max_d    = max_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (num_meas_i != '0)) begin
                    state_d  = S_CLEAR;
                    num_d    = num_meas_i;
                    sum_d    = '0;
                    n_d      = '0;
                    min_d    = '1;
                    max_d    = '0;
                    err_d    = 1'b0;
                    ph_cnt_d = PW'(CLR_CYCLES - 1);
                end
            end
            S_CLEAR: begin
                if (ph_cnt_q == '0) begin
                    state_d  = S_WAIT;
                    to_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q - PW'(1);
                end
            end
            S_WAIT: begin
                if (evt) begin
                    state_d  = S_SETTLE;
                    ph_cnt_d = PW'(1);
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_SETTLE: begin
                if (ph_cnt_q == '0) begin
                    cap_d   = intval_cnt_i;
                    state_d = S_ACCUM;
                end else begin
                    ph_cnt_d = ph_cnt_q - PW'(1);
                end
            end
            S_ACCUM: begin
                sum_d = sum_q + SW'(cap_q);
                n_d   = n_q + NUM_W'(1);
                if (cap_q < min_q) min_d = cap_q;
                if (cap_q > max_q) max_d = cap_q;
                if (n_d == num_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_CLEAR;
                    ph_cnt_d = PW'(CLR_CYCLES - 1);
                end
            end
            S_DONE: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            meas_rst_q <= 1'b1;
            num_q      <= '0;
            to_cnt_q   <= '0;
            ph_cnt_q   <= '0;
            cap_q      <= '0;
            sum_q      <= '0;
            n_q        <= '0;
            min_q      <= '1;
            max_q      <= '0;
            err_q      <= 1'b0;
            vld_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered from the next state so it tracks CLEAR exactly and
            // drops on the first edge after reset release.
            meas_rst_q <= (state_d == S_CLEAR);
            num_q      <= num_d;
            to_cnt_q   <= to_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            cap_q      <= cap_d;
            sum_q      <= sum_d;
            n_q        <= n_d;
            min_q      <= min_d;
            max_q      <= max_d;
            err_q      <= err_d;
            vld_prev_q <= vld_sync;
        end
    end

    assign meas_rst_o    = meas_rst_q;
    assign busy_o        = (state_q != S_IDLE);
    assign res_valid_o   = (state_q == S_DONE);
    assign err_timeout_o = err_q;
    assign res_sum_o     = sum_q;
    assign res_min_o     = min_q;
    assign res_max_o     = max_q;
    assign res_n_o       = n_q;

endmodule

// File: tb/tb_measure_ctrl.sv
// Bench for measure_ctrl: a behavioural datapath model answers each
// meas_rst release with the next queued interval count; expected results are
// queued at stimulus time and compared by a monitor when res_valid rises.
module tb_measure_ctrl;

    localparam int CW  = 32;
    localparam int NW  = 8;
    localparam int TO  = 64;
    localparam int CLR = 4;

    typedef struct {
        logic [CW+NW-1:0] sum;
        logic [CW-1:0]    mn;
        logic [CW-1:0]    mx;
        logic [NW-1:0]    n;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [NW-1:0]    num_meas = '0;
    logic [CW-1:0]    intval_cnt = '0;
    logic             cnt_valid = 1'b0;
    logic             meas_rst, busy, err_timeout, res_valid;
    logic             res_ready = 1'b1;
    logic [CW+NW-1:0] res_sum;
    logic [CW-1:0]    res_min, res_max;
    logic [NW-1:0]    res_n;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pulses = 0;
    bit          pw_en = 1'b0;
    exp_t        exp_q[$];
    logic [CW-1:0] dp_vals[$];

    measure_ctrl #(
        .CNT_WIDTH (CW),
        .NUM_W     (NW),
        .TIMEOUT   (TO),
        .CLR_CYCLES(CLR)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .num_meas_i   (num_meas),
        .intval_cnt_i (intval_cnt),
        .cnt_valid_i  (cnt_valid),
        .meas_rst_o   (meas_rst),
        .busy_o       (busy),
        .err_timeout_o(err_timeout),
        .res_sum_o    (res_sum),
        .res_min_o    (res_min),
        .res_max_o    (res_max),
        .res_n_o      (res_n),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push_exp(input logic [CW+NW-1:0] s, input logic [CW-1:0] mn,
                            input logic [CW-1:0] mx, input logic [NW-1:0] n, input logic err);
        exp_t e;
        e.sum = s; e.mn = mn; e.mx = mx; e.n = n; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [NW-1:0] n);
        @(negedge clk);
        start    = 1'b1;
        num_meas = n;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (busy) bound_fail(name);
    endtask

    // Datapath model: valid rises 6 cycles after meas_rst releases, cleared by meas_rst.
    initial begin : datapath
        int dly = 0;
        forever begin
            @(negedge clk);
            if (meas_rst) begin
                cnt_valid = 1'b0;
                dly = 0;
            end else if (!cnt_valid && dp_vals.size() > 0) begin
                if (dly == 5) begin
                    intval_cnt = dp_vals.pop_front();
                    cnt_valid  = 1'b1;
                end else begin
                    dly++;
                end
            end
        end
    end

    initial begin : monitor
        logic rv_prev;
        exp_t e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    bound_fail("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("res_sum", 64'(res_sum), 64'(e.sum));
                    check("res_min", 64'(res_min), 64'(e.mn));
                    check("res_max", 64'(res_max), 64'(e.mx));
                    check("res_n", 64'(res_n), 64'(e.n));
                    check("err_timeout", 64'(err_timeout), 64'(e.err));
                end
            end
            rv_prev = res_valid;
        end
    end

    initial begin : pulse_mon
        int w = 0;
        forever begin
            @(negedge clk);
            if (meas_rst) begin
                w++;
            end else begin
                if (w > 0 && pw_en) begin
                    check("meas_rst_width", 64'(w), 64'(CLR));
                    pulses++;
                end
                w = 0;
            end
        end
    end

    initial begin : stim
        int t0, t1, k, p0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_meas_rst", 64'(meas_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_sum", 64'(res_sum), 64'd0);
        check("rst_n", 64'(res_n), 64'd0);
        check("rst_min", 64'(res_min), 64'hFFFF_FFFF);
        check("rst_max", 64'(res_max), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("meas_rst_release", 64'(meas_rst), 64'd0);
        @(negedge clk);
        pw_en = 1'b1;

        // three measurements, pulse count
        pulses = 0;
        push_exp(310, 90, 120, 3, 1'b0);
        dp_vals = '{100, 120, 90};
        pulse_start(3);
        wait_idle("run3");
        check("meas_rst_pulses", 64'(pulses), 64'd3);

        // start with zero count is ignored
        pulse_start(0);
        repeat (3) @(negedge clk);
        check("num0_busy", 64'(busy), 64'd0);
        check("num0_meas_rst", 64'(meas_rst), 64'd0);

        // start while busy is ignored
        push_exp(30, 10, 20, 2, 1'b0);
        dp_vals = '{10, 20};
        pulse_start(2);
        repeat (3) @(negedge clk);
        pulse_start(5);
        wait_idle("run_busy_start");

        // full timeout with no completion
        push_exp(0, 32'hFFFF_FFFF, 0, 0, 1'b1);
        pulse_start(2);
        k = 0;
        while (meas_rst && k < 50) begin @(negedge clk); k++; end
        if (meas_rst) bound_fail("wait_entry");
        t0 = cyc;
        k = 0;
        while (!res_valid && k < 200) begin @(negedge clk); k++; end
        if (!res_valid) bound_fail("wait_timeout");
        t1 = cyc;
        check("timeout_latency", 64'(t1 - t0), 64'(TO));
        wait_idle("run_timeout");

        // timeout after one completed measurement
        push_exp(77, 77, 77, 1, 1'b1);
        dp_vals = '{77};
        pulse_start(3);
        wait_idle("run_partial");
        check("err_held_idle", 64'(err_timeout), 64'd1);

        // results held while res_ready low
        res_ready = 1'b0;
        push_exp(55, 55, 55, 1, 1'b0);
        dp_vals = '{55};
        pulse_start(1);
        k = 0;
        while (!res_valid && k < 200) begin @(negedge clk); k++; end
        if (!res_valid) bound_fail("wait_done");
        repeat (20) begin
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_sum", 64'(res_sum), 64'd55);
            check("hold_busy", 64'(busy), 64'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("ack_valid", 64'(res_valid), 64'd0);
        check("ack_busy", 64'(busy), 64'd0);

        // reset during WAIT of the second measurement
        dp_vals = '{200, 300, 400};
        p0 = pulses;
        pulse_start(3);
        k = 0;
        while (pulses < p0 + 2 && k < 500) begin @(negedge clk); k++; end
        if (pulses < p0 + 2) bound_fail("wait_second_meas");
        repeat (2) @(negedge clk);
        pw_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_meas_rst", 64'(meas_rst), 64'd1);
        check("midrst_valid", 64'(res_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        dp_vals.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pw_en = 1'b1;
        check("post_rst_n", 64'(res_n), 64'd0);
        push_exp(16, 7, 9, 2, 1'b0);
        dp_vals = '{7, 9};
        pulse_start(2);
        wait_idle("run_after_reset");
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
